alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
Sequencer that shares the single combinational `alu` between two requesters, for example the branch-compare path and the execute path. It arbitrates round-robin, registers the winning operands and drives them onto the ALU. It captures result/flags into a response register and holds them until the requester acknowledges. It also keeps operation and overflow event counters for debug.

Parameters:
CNT_W, 16, width of op_count and ovf_count (wrap-around counters)

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  2  per-requester request; bit i = requester i
req_ready  out  2  combinational accept strobe; at most one bit high
req_instruction  in  64  [31:0] requester 0, [63:32] requester 1; MIPS instruction word
req_regA  in  64  same packing; operand A
req_regB  in  64  same packing; operand B
resp_valid  out  2  registered; at most one bit high
resp_ready  in  2  per-requester response acknowledge
resp_result  out  32  captured ALU result
resp_flags  out  3  captured flags: [2]=zero, [1]=negative, [0]=overflow
alu_instruction  out  32  to alu.instruction, driven from operand register
alu_regA  out  32  to alu.regA
alu_regB  out  32  to alu.regB
alu_result  in  32  from alu.result
alu_flags  in  3  from alu.flags, same bit order as resp_flags
busy  out  1  high whenever state != IDLE
op_count  out  CNT_W  completed operations (response handshakes)
ovf_count  out  CNT_W  completed operations whose captured flags[0]=1

Behaviour:
- Reset and clock: synchronous, active-high; one clock domain.
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins first tie), winner reg=0.
  - Operand regs (alu_instruction/alu_regA/alu_regB)=0.
  - resp_valid=0, resp_result=0, resp_flags=0, busy=0, op_count=0, ovf_count=0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Winner selection: if exactly one req_valid bit is set, that requester wins. If both are set, the requester != last_grant wins.
  - req_ready[winner]=1 combinationally while in IDLE with any req_valid; otherwise req_ready=0.
  - On a clock edge with a request: latch the winner's instruction/regA/regB into operand regs, store winner, go to EXEC.
  - No request: stay in IDLE; operand regs hold their previous values.
- EXEC: the ALU evaluates the operand regs. At the clock edge, capture alu_result→resp_result and alu_flags→resp_flags, set resp_valid[winner]=1, go to RESP.
- RESP:
  - Hold resp_valid, resp_result and resp_flags stable until resp_ready[winner]=1.
  - On that edge: clear resp_valid, set last_grant=winner, op_count+=1, ovf_count+=resp_flags[0], go to IDLE.
  - resp_ready of the non-winner is ignored.
  - req_valid is ignored; no req_ready is asserted.
- Latency and throughput:
  - Request accepted at edge T → resp_valid high after edge T+1, i.e. during cycle T+2.
  - Minimum spacing between accepts is 3 cycles, with resp_ready tied high.
- Requester obligations: a requester keeps req_valid and its operands stable until its req_ready is seen. Dropping req_valid before the grant is legal; no operation results.
- Counters wrap modulo 2^CNT_W: 0xFFFF+1 → 0x0000 at the default width.
- Reset mid-operation (EXEC or RESP): the operation is discarded, no response is produced, counters clear, and last_grant returns to 1.
- Pure control: no arithmetic beyond the counters. The result is passed through unmodified, regardless of opcode (R/I-type decode stays in `alu`).

Test Plan:
- Single ADD from requester 0: instruction 0x00000020, A=0x7FFFFFFF, B=1 → req_ready=2'b01 at accept; resp_valid=2'b01 two cycles later; resp_result=0x80000000, resp_flags=3'b011; after ack op_count=1, ovf_count=1.
- Simultaneous requests right after reset: req0 SUB 0x00000022 with A=B=5; req1 OR 0x00000025 with A=0xC, B=0xA.
  - Requester 0 is served first: result 0, flags 3'b100.
  - Requester 1 is served next: result 0xE, flags 3'b000.
  - After both handshakes op_count=2.
- Fairness under continuous contention: both requesters valid for 6 operations → grants alternate 0,1,0,1,0,1; op_count=6.
- Response backpressure: resp_ready held 0 for 10 cycles in RESP → resp_valid, resp_result and resp_flags remain unchanged; no req_ready is asserted even with req_valid=2'b11; busy=1 throughout.
- Reset in EXEC: assert reset one cycle after accept → next cycle state IDLE, resp_valid=0, all counters 0; a subsequent single request from requester 1 completes normally.
- Counter wrap (CNT_W=4): run 16 operations with resp_ready=1 → op_count returns to 0; ovf_count counts only the ADD 0x7FFFFFFF+1 cases.

Source files
------------

// File: rtl/alu_share_ctrl_if.sv
// Requester-side bus of the shared-ALU sequencer: two packed request and response lanes.
interface alu_share_ctrl_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_instruction;
  logic [63:0] req_regA;
  logic [63:0] req_regB;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_result;
  logic [2:0]  resp_flags;

  // Requester side
  modport master (
    output req_valid, req_instruction, req_regA, req_regB, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_flags
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_instruction, req_regA, req_regB, resp_ready,
    output req_ready, resp_valid, resp_result, resp_flags
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Each operation runs IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold until ack).
module alu_share_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  alu_share_ctrl_if.slave      bus,
  output logic [31:0]          alu_instruction,
  output logic [31:0]          alu_regA,
  output logic [31:0]          alu_regB,
  input  logic [31:0]          alu_result,
  input  logic [2:0]           alu_flags,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count,
  output logic [CNT_W-1:0]     ovf_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nxt;
  logic               last_grant, last_grant_nxt;
  logic               winner, winner_nxt;
  logic               sel;
  logic [31:0]        instr_nxt, rega_nxt, regb_nxt;
  logic [1:0]         resp_valid_q, resp_valid_nxt;
  logic [31:0]        resp_result_q, resp_result_nxt;
  logic [2:0]         resp_flags_q, resp_flags_nxt;
  logic [CNT_W-1:0]   op_count_nxt, ovf_count_nxt;

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_flags  = resp_flags_q;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins
  always_comb begin
    sel = ~last_grant;
    if (bus.req_valid == 2'b01) begin
      sel = 1'b0;
    end else if (bus.req_valid == 2'b10) begin
      sel = 1'b1;
    end
  end

  // Next-state and next-register logic; req_ready is the only combinational output
  always_comb begin
    state_nxt       = state;
    bus.req_ready   = 2'b00;
    last_grant_nxt  = last_grant;
    winner_nxt      = winner;
    instr_nxt       = alu_instruction;
    rega_nxt        = alu_regA;
    regb_nxt        = alu_regB;
    resp_valid_nxt  = resp_valid_q;
    resp_result_nxt = resp_result_q;
    resp_flags_nxt  = resp_flags_q;
    op_count_nxt    = op_count;
    ovf_count_nxt   = ovf_count;
    unique case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          bus.req_ready[sel] = 1'b1;
          winner_nxt = sel;
          instr_nxt  = sel ? bus.req_instruction[63:32] : bus.req_instruction[31:0];
          rega_nxt   = sel ? bus.req_regA[63:32]        : bus.req_regA[31:0];
          regb_nxt   = sel ? bus.req_regB[63:32]        : bus.req_regB[31:0];
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        resp_result_nxt        = alu_result;
        resp_flags_nxt         = alu_flags;
        resp_valid_nxt         = 2'b00;
        resp_valid_nxt[winner] = 1'b1;
        state_nxt              = RESP;
      end
      RESP: begin
        if (bus.resp_ready[winner]) begin
          resp_valid_nxt = 2'b00;
          last_grant_nxt = winner;
          op_count_nxt   = op_count + CNT_W'(1);
          ovf_count_nxt  = ovf_count + CNT_W'(resp_flags_q[0]);
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand, response, arbitration and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant      <= 1'b1;
      winner          <= 1'b0;
      alu_instruction <= 32'd0;
      alu_regA        <= 32'd0;
      alu_regB        <= 32'd0;
      resp_valid_q    <= 2'b00;
      resp_result_q   <= 32'd0;
      resp_flags_q    <= 3'b000;
      busy            <= 1'b0;
      op_count        <= '0;
      ovf_count       <= '0;
    end else begin
      last_grant      <= last_grant_nxt;
      winner          <= winner_nxt;
      alu_instruction <= instr_nxt;
      alu_regA        <= rega_nxt;
      alu_regB        <= regb_nxt;
      resp_valid_q    <= resp_valid_nxt;
      resp_result_q   <= resp_result_nxt;
      resp_flags_q    <= resp_flags_nxt;
      busy            <= (state_nxt != IDLE);
      op_count        <= op_count_nxt;
      ovf_count       <= ovf_count_nxt;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small behavioural ALU (ADD/SUB/OR).
module tb_alu_share_ctrl;
  localparam int unsigned CW = 4;

  logic          clock;
  logic          reset;
  logic [31:0]   alu_instruction, alu_regA, alu_regB;
  logic [31:0]   alu_result;
  logic [2:0]    alu_flags;
  logic          busy;
  logic [CW-1:0] op_count, ovf_count;

  int tests = 0;
  int fails = 0;

  alu_share_ctrl_if bus();

  alu_share_ctrl #(.CNT_W(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus),
    .alu_instruction (alu_instruction),
    .alu_regA        (alu_regA),
    .alu_regB        (alu_regB),
    .alu_result      (alu_result),
    .alu_flags       (alu_flags),
    .busy            (busy),
    .op_count        (op_count),
    .ovf_count       (ovf_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: flags = {zero, negative, overflow}
  always_comb begin
    logic ov;
    ov = 1'b0;
    case (alu_instruction)
      32'h0000_0020: begin
        alu_result = alu_regA + alu_regB;
        ov = (alu_regA[31] == alu_regB[31]) && (alu_result[31] != alu_regA[31]);
      end
      32'h0000_0022: begin
        alu_result = alu_regA - alu_regB;
        ov = (alu_regA[31] != alu_regB[31]) && (alu_result[31] != alu_regA[31]);
      end
      32'h0000_0025: alu_result = alu_regA | alu_regB;
      default:       alu_result = 32'd0;
    endcase
    alu_flags = {alu_result == 32'd0, alu_result[31], ov};
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] v, input int r, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = v;
    if (r == 0) begin
      bus.req_instruction[31:0] = ins;
      bus.req_regA[31:0]        = a;
      bus.req_regB[31:0]        = b;
    end else begin
      bus.req_instruction[63:32] = ins;
      bus.req_regA[63:32]        = a;
      bus.req_regB[63:32]        = b;
    end
  endtask

  initial begin
    reset               = 1'b1;
    bus.req_valid       = 2'b00;
    bus.req_instruction = 64'd0;
    bus.req_regA        = 64'd0;
    bus.req_regB        = 64'd0;
    bus.resp_ready      = 2'b00;
    do_reset();

    // Reset state
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_op_count", 32'(op_count), 32'h0);
    chk("rst_ovf_count", 32'(ovf_count), 32'h0);
    chk("rst_alu_instr", alu_instruction, 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);

    // Single overflowing ADD from requester 0
    set_req(2'b01, 0, 32'h20, 32'h7FFF_FFFF, 32'h1);
    #1;
    chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    chk("t1_busy_exec", 32'(busy), 32'h1);
    chk("t1_alu_regA", alu_regA, 32'h7FFF_FFFF);
    chk("t1_resp_valid_exec", 32'(bus.resp_valid), 32'h0);
    tick();
    chk("t1_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("t1_result", bus.resp_result, 32'h8000_0000);
    chk("t1_flags", 32'(bus.resp_flags), 32'h3);
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    chk("t1_op_count", 32'(op_count), 32'h1);
    chk("t1_ovf_count", 32'(ovf_count), 32'h1);
    chk("t1_resp_cleared", 32'(bus.resp_valid), 32'h0);
    chk("t1_busy_idle", 32'(busy), 32'h0);

    // Simultaneous requests right after reset: requester 0 first
    do_reset();
    set_req(2'b11, 0, 32'h22, 32'h5, 32'h5);
    set_req(2'b11, 1, 32'h25, 32'hC, 32'hA);
    #1;
    chk("t2_tie_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b10;
    tick();
    chk("t2_resp_valid0", 32'(bus.resp_valid), 32'h1);
    chk("t2_result0", bus.resp_result, 32'h0);
    chk("t2_flags0", 32'(bus.resp_flags), 32'h4);
    chk("t2_no_ready_resp", 32'(bus.req_ready), 32'h0);
    bus.resp_ready = 2'b10;
    tick();
    chk("t2_wrong_ack_ignored", 32'(bus.resp_valid), 32'h1);
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    chk("t2_grant1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("t2_resp_valid1", 32'(bus.resp_valid), 32'h2);
    chk("t2_result1", bus.resp_result, 32'hE);
    chk("t2_flags1", 32'(bus.resp_flags), 32'h0);
    bus.resp_ready = 2'b10;
    tick();
    chk("t2_op_count", 32'(op_count), 32'h2);

    // Fairness under continuous contention with responses always accepted
    do_reset();
    set_req(2'b11, 0, 32'h20, 32'h1, 32'h2);
    set_req(2'b11, 1, 32'h20, 32'h3, 32'h4);
    bus.resp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("t3_grant_%0d", i), 32'(bus.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      tick();
      chk($sformatf("t3_resp_%0d", i), 32'(bus.resp_valid), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("t3_result_%0d", i), bus.resp_result, (i % 2 == 0) ? 32'h3 : 32'h7);
      tick();
    end
    chk("t3_op_count", 32'(op_count), 32'h6);

    // Response backpressure: everything holds while un-acknowledged
    bus.resp_ready = 2'b00;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_valid_%0d", i), 32'(bus.resp_valid), 32'h1);
      chk($sformatf("t4_result_%0d", i), bus.resp_result, 32'h3);
      chk($sformatf("t4_flags_%0d", i), 32'(bus.resp_flags), 32'h0);
      chk($sformatf("t4_ready_%0d", i), 32'(bus.req_ready), 32'h0);
      chk($sformatf("t4_busy_%0d", i), 32'(busy), 32'h1);
      tick();
    end
    bus.resp_ready = 2'b01;
    bus.req_valid  = 2'b00;
    tick();
    bus.resp_ready = 2'b00;
    chk("t4_op_count", 32'(op_count), 32'h7);

    // Reset while in EXEC discards the operation
    set_req(2'b01, 0, 32'h20, 32'h7FFF_FFFF, 32'h1);
    tick();
    bus.req_valid = 2'b00;
    chk("t5_in_exec", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("t5_op_count", 32'(op_count), 32'h0);
    chk("t5_ovf_count", 32'(ovf_count), 32'h0);
    tick();
    chk("t5_no_late_resp", 32'(bus.resp_valid), 32'h0);
    set_req(2'b10, 1, 32'h22, 32'h9, 32'h4);
    #1;
    chk("t5_grant1", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    chk("t5_resp_valid1", 32'(bus.resp_valid), 32'h2);
    chk("t5_result1", bus.resp_result, 32'h5);
    bus.resp_ready = 2'b10;
    tick();
    bus.resp_ready = 2'b00;
    chk("t5_op_after", 32'(op_count), 32'h1);

    // Counter wrap at 4 bits: 16 ops, every fourth one overflows
    do_reset();
    bus.resp_ready = 2'b01;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) set_req(2'b01, 0, 32'h20, 32'h7FFF_FFFF, 32'h1);
      else            set_req(2'b01, 0, 32'h20, 32'h1, 32'h1);
      tick();
      tick();
      tick();
      if (i == 14) begin
        chk("t6_op_count_15", 32'(op_count), 32'hF);
      end
    end
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b00;
    chk("t6_op_wrap", 32'(op_count), 32'h0);
    chk("t6_ovf_count", 32'(ovf_count), 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
